// File: rtl/circuito_tx_resposta_if.sv
// rtl/circuito_tx_resposta_if.sv - request/response signal bundle for the serial response transmitter
interface circuito_tx_resposta_if #(
    parameter int DATA_W = 7
);
    logic              partida;
    logic [DATA_W-1:0] dado;
    logic              saidaSerial;
    logic              ocupado;
    logic              fimTransmissao;
    logic [3:0]        dbEstado;

    // control unit side: issues requests, observes the line and status
    modport master (
        output partida,
        output dado,
        input  saidaSerial,
        input  ocupado,
        input  fimTransmissao,
        input  dbEstado
    );

    // transmitter side
    modport slave (
        input  partida,
        input  dado,
        output saidaSerial,
        output ocupado,
        output fimTransmissao,
        output dbEstado
    );
endinterface

// File: rtl/circuito_tx_resposta.sv
// rtl/circuito_tx_resposta.sv - LSB-first 7-bit serial transmitter, 2 stop bits, even parity when TX_PARIDADE_EN is defined
module circuito_tx_resposta #(
    parameter int CLK_POR_BIT = 5208,
    parameter int DATA_W      = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    circuito_tx_resposta_if.slave   bus
);

`ifdef TX_PARIDADE_EN
    localparam int NB = DATA_W + 4;
`else
    localparam int NB = DATA_W + 3;
`endif

    // CLK_POR_BIT-1 always fits in $clog2(CLK_POR_BIT) bits for CLK_POR_BIT >= 2
    localparam int              PW      = (CLK_POR_BIT > 1) ? $clog2(CLK_POR_BIT) : 1;
    localparam logic [PW-1:0]   PER_MAX = PW'(CLK_POR_BIT - 1);
    localparam logic [3:0]      BIT_MAX = 4'(NB - 1);

    typedef enum logic [3:0] {
        inicial     = 4'b0000,
        espera      = 4'b0001,
        transmissao = 4'b0010,
        final_tx    = 4'b0011
    } estado_t;

    estado_t         estado;
    estado_t         estado_next;
    logic [NB-1:0]   registrador;
    logic [3:0]      cont_bit;
    logic [PW-1:0]   cont_periodo;
    logic [NB-1:0]   quadro;
    logic            carrega;
    logic            fim_periodo;
    logic            serial_c;
    logic            ocupado_c;
    logic            fim_c;
    logic [3:0]      db_c;

    // frame as it leaves the line: start bit in bit 0, stop bits on top
`ifdef TX_PARIDADE_EN
    assign quadro = {2'b11, ^bus.dado, bus.dado, 1'b0};
`else
    assign quadro = {2'b11, bus.dado, 1'b0};
`endif

    assign fim_periodo = (cont_periodo == PER_MAX);

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= inicial;
        end else begin
            estado <= estado_next;
        end
    end

    // next-state and Moore outputs; line stays at mark outside transmissao
    always_comb begin
        estado_next = estado;
        carrega     = 1'b0;
        serial_c    = 1'b1;
        ocupado_c   = 1'b0;
        fim_c       = 1'b0;
        db_c        = 4'b1111;
        case (estado)
            inicial: begin
                db_c        = 4'b0000;
                estado_next = espera;
            end
            espera: begin
                db_c = 4'b0001;
                if (bus.partida) begin
                    carrega     = 1'b1;
                    estado_next = transmissao;
                end
            end
            transmissao: begin
                db_c      = 4'b0010;
                ocupado_c = 1'b1;
                serial_c  = registrador[0];
                if (fim_periodo && (cont_bit == BIT_MAX)) begin
                    estado_next = final_tx;
                end
            end
            final_tx: begin
                db_c        = 4'b0011;
                ocupado_c   = 1'b1;
                fim_c       = 1'b1;
                estado_next = espera;
            end
            default: begin
                db_c        = 4'b1111;
                estado_next = inicial;
            end
        endcase
    end

    // shift register and counters; the frame is captured only on the accepting edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            registrador  <= '1;
            cont_bit     <= '0;
            cont_periodo <= '0;
        end else if (carrega) begin
            registrador  <= quadro;
            cont_bit     <= '0;
            cont_periodo <= '0;
        end else if (estado == transmissao) begin
            if (fim_periodo) begin
                registrador  <= {1'b1, registrador[NB-1:1]};
                cont_bit     <= cont_bit + 4'd1;
                cont_periodo <= '0;
            end else begin
                cont_periodo <= cont_periodo + 1'b1;
            end
        end
    end

    assign bus.saidaSerial    = serial_c;
    assign bus.ocupado        = ocupado_c;
    assign bus.fimTransmissao = fim_c;
    assign bus.dbEstado       = db_c;

endmodule
